// File: rtl/chrono_ctrl.sv
// chrono_ctrl: button conditioning, stopwatch mode FSM and 1/100 s tick divider.
// Optional feature macro: CHRONO_DEBOUNCE_EN (adds a DB_CYCLES debounce filter per button).
module chrono_ctrl #(
  parameter int CLK_DIV   = 500000,
  parameter int LAPS      = 3,
  parameter int DB_CYCLES = 250000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic       btn_recall,
  output logic       run,
  output logic       tick,
  output logic       clr,
  output logic       lap_wr,
  output logic [1:0] lap_idx,
  output logic       recall_en,
  output logic [1:0] recall_idx,
  output logic [2:0] lap_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STOP   = 2'd2,
    ST_RECALL = 2'd3
  } state_e;

  localparam int              DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [1:0]      PTR_LAST  = 2'(LAPS - 1);
  localparam logic [2:0]      COUNT_MAX = 3'(LAPS);

  // Event bit positions shared by the conditioning pipeline and the FSM.
  localparam int B_START  = 0;
  localparam int B_LAP    = 1;
  localparam int B_CLEAR  = 2;
  localparam int B_RECALL = 3;

  if (CLK_DIV < 2 || LAPS < 1 || LAPS > 4 || DB_CYCLES < 1) begin : g_bad_params
    $error("chrono_ctrl: parameter out of range");
  end

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-flop synchronizer, optional debounce, rising edge.
  // ---------------------------------------------------------------------------
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] level;
  logic [3:0] level_q;
  logic [3:0] ev_d, ev_q;

  assign btn_raw = {btn_recall, btn_clear, btn_lap, btn_start};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples the pre-edge value of its source, which is what makes the
      // two synchronizer stages two distinct cycles.
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef CHRONO_DEBOUNCE_EN
  localparam int              DB_W    = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [3:0]      stable_d, stable_q;
  logic [DB_W-1:0] db_cnt_d [4];
  logic [DB_W-1:0] db_cnt_q [4];

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stable_q <= '0;
      // NOTE: the counter array is only four small registers, so it is reset
      // like any other state; a large storage array would be left unreset.
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign level = stable_q;
`else
  assign level = sync2_q;
`endif

  assign ev_d = level & ~level_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_q <= '0;
      ev_q    <= '0;
    end else begin
      level_q <= level;
      ev_q    <= ev_d;
    end
  end

  // One event per cycle: clear > start > lap > recall.
  logic ev_clear, ev_start, ev_lap, ev_recall;

  assign ev_clear  = ev_q[B_CLEAR];
  assign ev_start  = ev_q[B_START] & ~ev_q[B_CLEAR];
  assign ev_lap    = ev_q[B_LAP] & ~ev_q[B_CLEAR] & ~ev_q[B_START];
  assign ev_recall = ev_q[B_RECALL] & ~ev_q[B_CLEAR] & ~ev_q[B_START] & ~ev_q[B_LAP];

  // ---------------------------------------------------------------------------
  // Mode FSM, lap bookkeeping and tick divider.
  // ---------------------------------------------------------------------------
  state_e           state_d, state_q;
  state_e           ret_d, ret_q;
  logic [1:0]       wr_ptr_d, wr_ptr_q;
  logic [2:0]       lap_count_d, lap_count_q;
  logic [1:0]       recall_idx_d, recall_idx_q;
  logic [DIV_W-1:0] div_d, div_q;
  logic             run_d, run_q;
  logic             tick_d, tick_q;
  logic             clr_d, clr_q;
  logic             lap_wr_d, lap_wr_q;
  logic [1:0]       lap_idx_d, lap_idx_q;
  logic             recall_en_d, recall_en_q;
  logic             do_clear;

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    wr_ptr_d     = wr_ptr_q;
    lap_count_d  = lap_count_q;
    recall_idx_d = recall_idx_q;
    div_d        = div_q;
    tick_d       = 1'b0;
    clr_d        = 1'b0;
    lap_wr_d     = 1'b0;
    lap_idx_d    = '0;
    do_clear     = 1'b0;

    // The divider only advances while the registered state is RUN, so it
    // keeps its sub-tick phase across stop/resume.
    if (state_q == ST_RUN) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (ev_clear) begin
          do_clear = 1'b1;
        end else if (ev_start) begin
          state_d = ST_RUN;
        end else if (ev_recall && lap_count_q != 3'd0) begin
          state_d      = ST_RECALL;
          ret_d        = ST_IDLE;
          recall_idx_d = '0;
        end
      end
      ST_RUN: begin
        if (ev_start) begin
          state_d = ST_STOP;
        end else if (ev_lap) begin
          lap_wr_d  = 1'b1;
          lap_idx_d = wr_ptr_q;
          wr_ptr_d  = (wr_ptr_q == PTR_LAST) ? 2'd0 : wr_ptr_q + 2'd1;
          if (lap_count_q != COUNT_MAX) lap_count_d = lap_count_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (ev_clear) begin
          do_clear = 1'b1;
        end else if (ev_start) begin
          state_d = ST_RUN;
        end else if (ev_recall && lap_count_q != 3'd0) begin
          state_d      = ST_RECALL;
          ret_d        = ST_STOP;
          recall_idx_d = '0;
        end
      end
      ST_RECALL: begin
        if (ev_clear) begin
          do_clear = 1'b1;
        end else if (ev_start) begin
          state_d = ret_q;
        end else if (ev_recall) begin
          recall_idx_d = ({1'b0, recall_idx_q} + 3'd1 == lap_count_q) ? 2'd0
                                                                      : recall_idx_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_clear) begin
      state_d      = ST_IDLE;
      clr_d        = 1'b1;
      div_d        = '0;
      wr_ptr_d     = '0;
      lap_count_d  = '0;
      recall_idx_d = '0;
    end

    run_d       = (state_d == ST_RUN);
    recall_en_d = (state_d == ST_RECALL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ret_q        <= ST_IDLE;
      wr_ptr_q     <= '0;
      lap_count_q  <= '0;
      recall_idx_q <= '0;
      div_q        <= '0;
      run_q        <= 1'b0;
      tick_q       <= 1'b0;
      clr_q        <= 1'b0;
      lap_wr_q     <= 1'b0;
      lap_idx_q    <= '0;
      recall_en_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      wr_ptr_q     <= wr_ptr_d;
      lap_count_q  <= lap_count_d;
      recall_idx_q <= recall_idx_d;
      div_q        <= div_d;
      run_q        <= run_d;
      tick_q       <= tick_d;
      clr_q        <= clr_d;
      lap_wr_q     <= lap_wr_d;
      lap_idx_q    <= lap_idx_d;
      recall_en_q  <= recall_en_d;
    end
  end

  assign run        = run_q;
  assign tick       = tick_q;
  assign clr        = clr_q;
  assign lap_wr     = lap_wr_q;
  assign lap_idx    = lap_idx_q;
  assign recall_en  = recall_en_q;
  assign recall_idx = recall_idx_q;
  assign lap_count  = lap_count_q;

endmodule

// File: tb/tb_chrono_ctrl.sv
// Self-checking bench for chrono_ctrl: directed sequences, a vector table and
// random button presses checked against an event-level stopwatch model.
module tb_chrono_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int LAPS      = 3;
  localparam int DB_CYCLES = 8;

  localparam logic [3:0] B_NONE   = 4'b0000;
  localparam logic [3:0] B_START  = 4'b0001;
  localparam logic [3:0] B_LAP    = 4'b0010;
  localparam logic [3:0] B_CLEAR  = 4'b0100;
  localparam logic [3:0] B_RECALL = 4'b1000;

  logic       clock;
  logic       reset;
  logic       btn_start, btn_lap, btn_clear, btn_recall;
  logic       run, tick, clr, lap_wr, recall_en;
  logic [1:0] lap_idx, recall_idx;
  logic [2:0] lap_count;

  int n_checks = 0;
  int n_pass   = 0;

  chrono_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .LAPS     (LAPS),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .btn_clear (btn_clear),
    .btn_recall(btn_recall),
    .run       (run),
    .tick      (tick),
    .clr       (clr),
    .lap_wr    (lap_wr),
    .lap_idx   (lap_idx),
    .recall_en (recall_en),
    .recall_idx(recall_idx),
    .lap_count (lap_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks the stopwatch at the level of modes, total laps
  // taken, recall presses and cycles spent running since the last clear.
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_RUN, M_STOP, M_RECALL} mode_e;

  mode_e      m_mode, m_ret;
  int         m_run_cycles, m_laps, m_recalls;
  logic [3:0] m_hist [5];
  bit         e_tick, e_clr, e_lap_wr;
  int         e_lap_idx;
  bit         model_on;

  function automatic int m_count();
    return (m_laps < LAPS) ? m_laps : LAPS;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_ret  = M_IDLE;
    m_run_cycles = 0;
    m_laps = 0;
    m_recalls = 0;
    for (int k = 0; k < 5; k++) m_hist[k] = B_NONE;
    e_tick = 0;
    e_clr = 0;
    e_lap_wr = 0;
    e_lap_idx = 0;
  endtask

  // One active clock edge; b is the button level sampled at this edge. A press
  // takes effect three edges after it is first sampled high.
  task automatic model_edge(input logic [3:0] b);
    logic [3:0] ev;
    logic [3:0] pick;
    bit         clear_now;
    for (int k = 4; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = b;
    ev = m_hist[3] & ~m_hist[4];
    e_tick = 0;
    e_clr = 0;
    e_lap_wr = 0;
    clear_now = 0;
    if (m_mode == M_RUN) begin
      m_run_cycles++;
      e_tick = (m_run_cycles % CLK_DIV) == 0;
    end
    pick = ev[2] ? B_CLEAR : ev[0] ? B_START : ev[1] ? B_LAP : ev[3] ? B_RECALL : B_NONE;
    case (m_mode)
      M_IDLE, M_STOP: begin
        if (pick == B_CLEAR) clear_now = 1;
        else if (pick == B_START) m_mode = M_RUN;
        else if (pick == B_RECALL && m_count() > 0) begin
          m_ret = m_mode;
          m_mode = M_RECALL;
          m_recalls = 0;
        end
      end
      M_RUN: begin
        if (pick == B_START) m_mode = M_STOP;
        else if (pick == B_LAP) begin
          e_lap_wr = 1;
          e_lap_idx = m_laps % LAPS;
          m_laps++;
        end
      end
      M_RECALL: begin
        if (pick == B_CLEAR) clear_now = 1;
        else if (pick == B_START) m_mode = m_ret;
        else if (pick == B_RECALL) m_recalls++;
      end
      default: ;
    endcase
    if (clear_now) begin
      e_clr = 1;
      m_mode = M_IDLE;
      m_run_cycles = 0;
      m_laps = 0;
      m_recalls = 0;
    end
  endtask

  task automatic compare_model();
    check("run", int'(run), int'(m_mode == M_RUN));
    check("tick", int'(tick), int'(e_tick));
    check("clr", int'(clr), int'(e_clr));
    check("lap_wr", int'(lap_wr), int'(e_lap_wr));
    if (e_lap_wr) check("lap_idx", int'(lap_idx), e_lap_idx);
    check("recall_en", int'(recall_en), int'(m_mode == M_RECALL));
    if (m_mode == M_RECALL) check("recall_idx", int'(recall_idx), m_recalls % m_count());
    check("lap_count", int'(lap_count), m_count());
  endtask

  // Drive buttons at the falling edge, let one rising edge pass, compare at
  // the next falling edge.
  task automatic cycle(input logic [3:0] b);
    {btn_recall, btn_clear, btn_lap, btn_start} = b;
    @(posedge clock);
    if (model_on) model_edge(b);
    @(negedge clock);
    if (model_on) compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(B_NONE);
  endtask

  task automatic apply_reset(input string tag);
    {btn_recall, btn_clear, btn_lap, btn_start} = B_NONE;
    reset = 1'b0;
    #1;
    check({tag, "_outputs_zero"},
          int'({run, tick, clr, lap_wr, recall_en, lap_idx, recall_idx, lap_count}), 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [3:0] btn;
    logic       run;
    logic       recall_en;
    logic [1:0] recall_idx;
    logic [2:0] lap_count;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[22];
    int   ticks;
    bit   tick_at[30];
    bit   run_at[30];
    int   exp_idx[4];
    int   exp_cnt[4];
    int   got_idx, got_cnt, pulses, sum;
    logic [3:0] b;

    vecs[0]  = '{B_START,           1'b1, 1'b0, 2'd0, 3'd0};
    vecs[1]  = '{B_LAP,             1'b1, 1'b0, 2'd0, 3'd1};
    vecs[2]  = '{B_LAP,             1'b1, 1'b0, 2'd0, 3'd2};
    vecs[3]  = '{B_START,           1'b0, 1'b0, 2'd0, 3'd2};
    vecs[4]  = '{B_RECALL,          1'b0, 1'b1, 2'd0, 3'd2};
    vecs[5]  = '{B_RECALL,          1'b0, 1'b1, 2'd1, 3'd2};
    vecs[6]  = '{B_RECALL,          1'b0, 1'b1, 2'd0, 3'd2};
    vecs[7]  = '{B_START,           1'b0, 1'b0, 2'd0, 3'd2};
    vecs[8]  = '{B_LAP,             1'b0, 1'b0, 2'd0, 3'd2};
    vecs[9]  = '{B_START,           1'b1, 1'b0, 2'd0, 3'd2};
    vecs[10] = '{B_CLEAR,           1'b1, 1'b0, 2'd0, 3'd2};
    vecs[11] = '{B_LAP,             1'b1, 1'b0, 2'd0, 3'd3};
    vecs[12] = '{B_LAP,             1'b1, 1'b0, 2'd0, 3'd3};
    vecs[13] = '{B_START,           1'b0, 1'b0, 2'd0, 3'd3};
    vecs[14] = '{B_CLEAR | B_START, 1'b0, 1'b0, 2'd0, 3'd0};
    vecs[15] = '{B_RECALL,          1'b0, 1'b0, 2'd0, 3'd0};
    vecs[16] = '{B_START,           1'b1, 1'b0, 2'd0, 3'd0};
    vecs[17] = '{B_LAP,             1'b1, 1'b0, 2'd0, 3'd1};
    vecs[18] = '{B_START,           1'b0, 1'b0, 2'd0, 3'd1};
    vecs[19] = '{B_RECALL,          1'b0, 1'b1, 2'd0, 3'd1};
    vecs[20] = '{B_RECALL,          1'b0, 1'b1, 2'd0, 3'd1};
    vecs[21] = '{B_CLEAR,           1'b0, 1'b0, 2'd0, 3'd0};
    exp_idx = '{0, 1, 2, 0};
    exp_cnt = '{1, 2, 3, 3};

    reset = 1'b0;
    {btn_recall, btn_clear, btn_lap, btn_start} = B_NONE;
    model_reset();
    model_on = 1;
    repeat (2) @(negedge clock);
    check("reset_outputs_zero",
          int'({run, tick, clr, lap_wr, recall_en, lap_idx, recall_idx, lap_count}), 0);
    reset = 1'b1;

`ifdef CHRONO_DEBOUNCE_EN
    model_on = 0;
    for (int i = 0; i < 5; i++) cycle(B_START);
    idle(20);
    check("glitch_no_event", int'(run), 0);
    for (int i = 0; i < 12; i++) cycle(B_START);
    idle(20);
    check("press_one_event", int'(run), 1);
`else
    // Start latency and tick rate.
    cycle(B_START);
    idle(2);
    check("run_before_latency", int'(run), 0);
    idle(1);
    check("run_after_latency", int'(run), 1);
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(B_NONE);
      ticks += int'(tick);
    end
    check("ticks_in_40_cycles", ticks, 10);

    // Divider phase held across stop/resume.
    apply_reset("phase");
    for (int i = 0; i < 30; i++) begin
      cycle((i == 0 || i == 6 || i == 16) ? B_START : B_NONE);
      tick_at[i] = tick;
      run_at[i]  = run;
    end
    check("first_tick", int'(tick_at[7]), 1);
    sum = 0;
    for (int i = 8; i < 21; i++) sum += int'(tick_at[i]);
    check("no_ticks_while_stopped", sum, 0);
    check("stopped_run", int'(run_at[9]), 0);
    check("resume_run", int'(run_at[19]), 1);
    check("resume_tick", int'(tick_at[21]), 1);

    // Lap slots wrap and lap_count saturates.
    apply_reset("laps");
    cycle(B_START);
    idle(3);
    for (int j = 0; j < 4; j++) begin
      pulses = 0;
      got_idx = -1;
      got_cnt = -1;
      for (int k = 0; k < 4; k++) begin
        cycle((k == 0) ? B_LAP : B_NONE);
        if (lap_wr) begin
          pulses++;
          got_idx = int'(lap_idx);
          got_cnt = int'(lap_count);
        end
      end
      check($sformatf("lap%0d_pulses", j), pulses, 1);
      check($sformatf("lap%0d_idx", j), got_idx, exp_idx[j]);
      check($sformatf("lap%0d_count", j), got_cnt, exp_cnt[j]);
    end

    // Vector table: one press, let it settle, compare against constants.
    apply_reset("table");
    for (int i = 0; i < 22; i++) begin
      cycle(vecs[i].btn);
      idle(5);
      check($sformatf("vec%0d_run", i), int'(run), int'(vecs[i].run));
      check($sformatf("vec%0d_recall_en", i), int'(recall_en), int'(vecs[i].recall_en));
      if (vecs[i].recall_en)
        check($sformatf("vec%0d_recall_idx", i), int'(recall_idx), int'(vecs[i].recall_idx));
      check($sformatf("vec%0d_lap_count", i), int'(lap_count), int'(vecs[i].lap_count));
    end

    // Reset in the middle of a lap_wr pulse, then while running.
    apply_reset("pre_mid_lap");
    cycle(B_START);
    idle(3);
    cycle(B_LAP);
    idle(3);
    check("lap_wr_before_reset", int'(lap_wr), 1);
    apply_reset("mid_lap");
    idle(6);
    check("idle_after_mid_lap_reset", int'(run), 0);
    cycle(B_START);
    idle(3);
    check("run_before_reset", int'(run), 1);
    apply_reset("in_run");
    idle(4);
    check("idle_after_run_reset", int'({run, lap_count}), 0);

    // A held button is one event.
    apply_reset("held");
    for (int i = 0; i < 10; i++) cycle(B_START);
    idle(10);
    check("held_start_one_event", int'(run), 1);

    // Random single-button presses against the model.
    apply_reset("random");
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: b = B_START;
        3, 4, 5: b = B_LAP;
        6, 7:    b = B_RECALL;
        default: b = ($urandom_range(0, 3) == 0) ? B_CLEAR : B_RECALL;
      endcase
      for (int h = 0; h < int'($urandom_range(1, 3)); h++) cycle(b);
      idle(int'($urandom_range(2, 5)));
    end
    idle(6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chrono_ctrl.md
# chrono_ctrl

Front-end controller for the stopwatch datapath. It conditions the four raw push-buttons and runs the stopwatch mode state machine (idle, running, stopped, recall). It also generates the 1/100 s count enable, and produces the clear, lap-write and lap-recall controls that sequence the counter/lap-store block. It sits between the board buttons and the counter datapath, and is the only block that drives the datapath's control inputs.

## Interface
- CLK_DIV, 500000: system clocks per 1/100 s tick (50 MHz → 100 Hz); minimum 2.
- LAPS, 3: lap slots in the datapath store; 1..4.
- DB_CYCLES, 250000: cycles a synchronized button must hold a new level to be accepted (5 ms at 50 MHz); used only with CHRONO_DEBOUNCE_EN.
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- btn_start  in  1  raw start/stop button, active-high, asynchronous to clock.
- btn_lap  in  1  raw lap button, active-high.
- btn_clear  in  1  raw clear button, active-high.
- btn_recall  in  1  raw recall button, active-high.
- run  out  1  high while state is RUN.
- tick  out  1  one-cycle count enable to datapath.
- clr  out  1  one-cycle datapath clear.
- lap_wr  out  1  one-cycle lap capture strobe.
- lap_idx  out  2  slot written by lap_wr; valid only while lap_wr=1.
- recall_en  out  1  high while state is RECALL; datapath displays the stored lap.
- recall_idx  out  2  slot displayed while recall_en=1.
- lap_count  out  3  laps stored, 0..LAPS, saturating.

## Operation
- Each button passes through a 2-flop synchronizer, then an optional debounce, then a rising-edge detector. The result is a one-cycle press event: ev_start, ev_lap, ev_clear, ev_recall.
- Only one event is acted on per cycle. Priority: clear > start > lap > recall. Lower-priority events in the same cycle are dropped.
- States: IDLE (reset state), RUN, STOP, RECALL.
- IDLE:
  - start → RUN.
  - clear → clr pulse; stay in IDLE.
  - recall with lap_count>0 → RECALL, recall_idx=0, return state=IDLE.
  - lap ignored.
- RUN:
  - start → STOP.
  - lap → lap_wr pulse with lap_idx=wr_ptr; wr_ptr advances and wraps LAPS-1→0; lap_count increments, saturating at LAPS.
  - clear and recall ignored.
- STOP:
  - start → RUN.
  - clear → clr pulse; wr_ptr, lap_count and divider cleared; go to IDLE.
  - recall with lap_count>0 → RECALL, recall_idx=0, return state=STOP.
  - lap ignored.
- RECALL:
  - recall → recall_idx advances, wrapping lap_count-1→0.
  - start → return state; does not start counting.
  - clear → same as clear in STOP, go to IDLE.
  - lap ignored.
- Tick divider:
  - Counts 0..CLK_DIV-1 only while the state register is RUN.
  - tick=1 in the cycle the count equals CLK_DIV-1, then the count wraps to 0.
  - Holds its value outside RUN, so resume keeps the sub-tick phase.
  - Cleared to 0 by any clear event.
- Once lap_count reaches LAPS, further laps overwrite the oldest slot.

## Timing
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - run, tick, clr, lap_wr, recall_en = 0.
  - lap_idx, recall_idx, lap_count, wr_ptr, divider = 0.
  - Synchronizer, debounce and edge-detect registers = 0.
- Release of reset takes effect on the next clock edge.
- All outputs are registered.
- Without debounce: button first sampled high at edge N → event registered at N+2 → output/state change visible after edge N+3. This is 3 cycles of latency.
- With debounce: latency adds DB_CYCLES.
- run rises in the same cycle the state becomes RUN. The first tick follows CLK_DIV cycles later when starting from divider=0.
- clr and lap_wr are exactly one cycle wide.
- A held button produces exactly one event.
- Reset asserted mid-pulse truncates the pulse immediately.

## Configuration
- CHRONO_DEBOUNCE_EN defined:
  - Each synchronized button has a debounce counter.
  - The accepted level changes only after DB_CYCLES consecutive cycles at the new level.
  - Glitches shorter than DB_CYCLES produce no event.
- CHRONO_DEBOUNCE_EN undefined:
  - No debounce counters; DB_CYCLES unused.
  - Every synchronized rising edge is an event.

## Test plan
All scenarios use CLK_DIV=4, LAPS=3, macro undefined.
- Reset, then start pulse → run=1 three cycles later; tick pulses every 4th cycle; 10 ticks after 40 cycles.
- Start, 6 cycles, start, 10 cycles, start → divider phase held: the first tick after resume comes 2 cycles later; no ticks while stopped.
- In RUN, 4 lap presses → lap_wr with lap_idx 0,1,2,0; lap_count 1,2,3,3.
- In STOP with lap_count=2, recall ×3 → recall_idx 0,1,0. Then start → STOP, recall_en=0, run=0.
- clear and start in the same cycle while in STOP → clr pulse, IDLE, lap_count=0, run stays 0. clear in RUN → ignored.
- Reset asserted during lap_wr and while in RUN → all outputs 0 asynchronously; state IDLE after release.
- With the macro defined, DB_CYCLES=8: a 5-cycle button glitch gives no event; a 12-cycle press gives exactly one event.
